// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter in front of a single shared slave.
// Master 0 (CPU) and master 1 (DMA) share the slave round-robin. Each grant
// lasts for the whole cycle (bus lock). A stalled slave or a slave that never
// acks is cut off after TIMEOUT strobe cycles. The owning master then gets a
// one-cycle err and the bus parks in ABORT until that master drops cyc.
module wb_master_arbiter #(
  parameter int TIMEOUT = 1000,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                i_clk,
  input  logic                in_rst,
  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  input  logic                i_m0_we,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic [DATA_W-1:0]   i_m0_data,
  input  logic [DATA_W/8-1:0] i_m0_sel,
  output logic                o_m0_ack,
  output logic                o_m0_stall,
  output logic                o_m0_err,
  output logic [DATA_W-1:0]   o_m0_data,
  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  input  logic                i_m1_we,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic [DATA_W-1:0]   i_m1_data,
  input  logic [DATA_W/8-1:0] i_m1_sel,
  output logic                o_m1_ack,
  output logic                o_m1_stall,
  output logic                o_m1_err,
  output logic [DATA_W-1:0]   o_m1_data,
  output logic                o_s_cyc,
  output logic                o_s_stb,
  output logic                o_s_we,
  output logic [ADDR_W-1:0]   o_s_addr,
  output logic [DATA_W-1:0]   o_s_data,
  output logic [DATA_W/8-1:0] o_s_sel,
  input  logic                i_s_ack,
  input  logic                i_s_stall,
  input  logic [DATA_W-1:0]   i_s_data,
  output logic [1:0]          o_grant,
  output logic [7:0]          o_abort_cnt
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT0  = 2'd1;
  localparam logic [1:0] ST_GNT1  = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;       // 0 = m0 owned last, 1 = m1 owned last
  logic       abort_m_q, abort_m_d; // master whose cycle was aborted
  logic [9:0] tmo_q, tmo_d;
  logic [7:0] abort_cnt_q, abort_cnt_d;

  logic gnt0_s, gnt1_s, tmo_hit_s;

  assign gnt0_s = (state_q == ST_GNT0);
  assign gnt1_s = (state_q == ST_GNT1);

  // Slave-side mux: the owner drives the slave. Otherwise the bus is quiet. A stb without cyc is masked off.
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_addr = {ADDR_W{1'b0}};
    o_s_data = {DATA_W{1'b0}};
    o_s_sel  = {SEL_W{1'b0}};
    if (gnt0_s) begin
      o_s_cyc  = i_m0_cyc;
      o_s_stb  = i_m0_cyc & i_m0_stb;
      o_s_we   = i_m0_we;
      o_s_addr = i_m0_addr;
      o_s_data = i_m0_data;
      o_s_sel  = i_m0_sel;
    end else if (gnt1_s) begin
      o_s_cyc  = i_m1_cyc;
      o_s_stb  = i_m1_cyc & i_m1_stb;
      o_s_we   = i_m1_we;
      o_s_addr = i_m1_addr;
      o_s_data = i_m1_data;
      o_s_sel  = i_m1_sel;
    end else begin
      o_s_cyc  = 1'b0;
    end
  end

  // A strobed cycle has reached its last allowed wait with no ack. An ack in this same cycle wins.
  assign tmo_hit_s = (gnt0_s | gnt1_s) & o_s_stb & ~i_s_ack & (tmo_q == TMO_LAST);

  // Master-side responses: only the owner sees the slave. Everyone else sees stall.
  always_comb begin
    o_m0_ack   = gnt0_s & i_s_ack;
    o_m0_err   = gnt0_s & tmo_hit_s;
    o_m0_stall = gnt0_s ? i_s_stall : 1'b1;
    o_m0_data  = gnt0_s ? i_s_data : {DATA_W{1'b0}};
    o_m1_ack   = gnt1_s & i_s_ack;
    o_m1_err   = gnt1_s & tmo_hit_s;
    o_m1_stall = gnt1_s ? i_s_stall : 1'b1;
    o_m1_data  = gnt1_s ? i_s_data : {DATA_W{1'b0}};
    o_grant    = {gnt1_s, gnt0_s};
  end

  assign o_abort_cnt = abort_cnt_q;

  // Arbitration FSM: round-robin on ties, lock while cyc is held, hand over directly on release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_m0_cyc && i_m1_cyc) state_d = last_q ? ST_GNT0 : ST_GNT1;
        else if (i_m0_cyc)        state_d = ST_GNT0;
        else if (i_m1_cyc)        state_d = ST_GNT1;
        else                      state_d = ST_IDLE;
      end
      ST_GNT0: begin
        if (tmo_hit_s)      state_d = ST_ABORT;
        else if (!i_m0_cyc) state_d = i_m1_cyc ? ST_GNT1 : ST_IDLE;
        else                state_d = ST_GNT0;
      end
      ST_GNT1: begin
        if (tmo_hit_s)      state_d = ST_ABORT;
        else if (!i_m1_cyc) state_d = i_m0_cyc ? ST_GNT0 : ST_IDLE;
        else                state_d = ST_GNT1;
      end
      ST_ABORT: begin
        if (!(abort_m_q ? i_m1_cyc : i_m0_cyc)) state_d = ST_IDLE;
        else                                    state_d = ST_ABORT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Side registers: last owner, aborted master, timeout counter and the saturating abort count.
  always_comb begin
    last_d      = last_q;
    abort_m_d   = abort_m_q;
    tmo_d       = tmo_q;
    abort_cnt_d = abort_cnt_q;
    if (state_d != state_q && state_d == ST_GNT0)      last_d = 1'b0;
    else if (state_d != state_q && state_d == ST_GNT1) last_d = 1'b1;
    else                                               last_d = last_q;
    if (tmo_hit_s) begin
      abort_m_d = gnt1_s;
      if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
      else                      abort_cnt_d = abort_cnt_q;
    end else begin
      abort_m_d = abort_m_q;
    end
    if (state_d != state_q || i_s_ack)      tmo_d = 10'd0;
    else if ((gnt0_s | gnt1_s) && o_s_stb)  tmo_d = tmo_q + 10'd1;
    else                                    tmo_d = tmo_q;
  end

  // State and bookkeeping registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      abort_m_q   <= 1'b0;
      tmo_q       <= 10'd0;
      abort_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      abort_m_q   <= abort_m_d;
      tmo_q       <= tmo_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter (TIMEOUT = 8): directed scenarios
// plus a randomized phase, compared against an ownership-level reference model.
module tb_wb_master_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel  [2];
  logic        s_ack, s_stall;
  logic [31:0] s_data;

  logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_wdat;
  logic [3:0]  s_sel;
  logic [1:0]  grant;
  logic [7:0]  abort_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: who owns the bus, whether it is parked after an abort
  int owner;     // -1 = nobody, 0 or 1
  bit in_abort;
  int abort_m;
  int last;
  int waited;    // strobed cycles without ack since grant or last ack
  int aborts;

  wb_master_arbiter #(.TIMEOUT(TMO), .ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .in_rst(rst_n),
    .i_m0_cyc(cyc[0]), .i_m0_stb(stb[0]), .i_m0_we(we[0]),
    .i_m0_addr(addr[0]), .i_m0_data(wdat[0]), .i_m0_sel(sel[0]),
    .o_m0_ack(m0_ack), .o_m0_stall(m0_stall), .o_m0_err(m0_err), .o_m0_data(m0_rdat),
    .i_m1_cyc(cyc[1]), .i_m1_stb(stb[1]), .i_m1_we(we[1]),
    .i_m1_addr(addr[1]), .i_m1_data(wdat[1]), .i_m1_sel(sel[1]),
    .o_m1_ack(m1_ack), .o_m1_stall(m1_stall), .o_m1_err(m1_err), .o_m1_data(m1_rdat),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
    .o_s_addr(s_addr), .o_s_data(s_wdat), .o_s_sel(s_sel),
    .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_data),
    .o_grant(grant), .o_abort_cnt(abort_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; in_abort = 1'b0; abort_m = 0; last = 1; waited = 0; aborts = 0;
  endtask

  // One bus cycle: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit g0, g1, hit;
    int o, nxt;
    bit nxt_ab, changed;
    @(negedge clk);
    g0  = !in_abort && owner == 0;
    g1  = !in_abort && owner == 1;
    o   = g1 ? 1 : 0;
    hit = (g0 || g1) && cyc[o] && stb[o] && !s_ack && waited == TMO - 1;
    chk("grant",    {62'd0, grant}, {62'd0, g1, g0});
    chk("s_cyc",    {63'd0, s_cyc}, (g0 || g1) ? {63'd0, cyc[o]} : 64'd0);
    chk("s_stb",    {63'd0, s_stb}, (g0 || g1) ? {63'd0, cyc[o] & stb[o]} : 64'd0);
    chk("s_we",     {63'd0, s_we},  (g0 || g1) ? {63'd0, we[o]} : 64'd0);
    chk("s_addr",   {32'd0, s_addr}, (g0 || g1) ? {32'd0, addr[o]} : 64'd0);
    chk("s_data",   {32'd0, s_wdat}, (g0 || g1) ? {32'd0, wdat[o]} : 64'd0);
    chk("s_sel",    {60'd0, s_sel},  (g0 || g1) ? {60'd0, sel[o]} : 64'd0);
    chk("m0_ack",   {63'd0, m0_ack},   {63'd0, g0 & s_ack});
    chk("m0_stall", {63'd0, m0_stall}, g0 ? {63'd0, s_stall} : 64'd1);
    chk("m0_err",   {63'd0, m0_err},   {63'd0, g0 & hit});
    chk("m0_data",  {32'd0, m0_rdat},  g0 ? {32'd0, s_data} : 64'd0);
    chk("m1_ack",   {63'd0, m1_ack},   {63'd0, g1 & s_ack});
    chk("m1_stall", {63'd0, m1_stall}, g1 ? {63'd0, s_stall} : 64'd1);
    chk("m1_err",   {63'd0, m1_err},   {63'd0, g1 & hit});
    chk("m1_data",  {32'd0, m1_rdat},  g1 ? {32'd0, s_data} : 64'd0);
    chk("abort_cnt", {56'd0, abort_cnt}, 64'(aborts));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      nxt = owner; nxt_ab = in_abort;
      if (in_abort) begin
        if (!cyc[abort_m]) begin nxt_ab = 1'b0; nxt = -1; end
      end else if (owner < 0) begin
        if (cyc == 2'b11) nxt = 1 - last;
        else if (cyc[0])  nxt = 0;
        else if (cyc[1])  nxt = 1;
      end else if (hit) begin
        nxt_ab = 1'b1; abort_m = owner; nxt = -1;
        if (aborts < 255) aborts++;
      end else if (!cyc[owner]) begin
        nxt = cyc[1 - owner] ? 1 - owner : -1;
      end
      changed = (nxt != owner) || (nxt_ab != in_abort);
      if (changed || s_ack) waited = 0;
      else if ((g0 || g1) && cyc[o] && stb[o]) waited++;
      if (changed && nxt >= 0) last = nxt;
      owner = nxt; in_abort = nxt_ab;
    end
    #1;
  endtask

  task automatic idle_inputs();
    cyc = 2'b00; stb = 2'b00; s_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cyc = 2'b00; stb = 2'b00; we = 2'b00;
    addr[0] = 32'h0; addr[1] = 32'h0; wdat[0] = 32'h0; wdat[1] = 32'h0;
    sel[0] = 4'h0; sel[1] = 4'h0;
    s_ack = 1'b0; s_stall = 1'b0; s_data = 32'h0;
    model_reset();
    cycle(); cycle();
    chk("reset_m0_stall", {63'd0, m0_stall}, 64'd1);
    rst_n = 1'b1;

    // both masters request at once: m0 wins the first tie, m1 follows without an idle cycle
    cyc = 2'b11; stb = 2'b11;
    we[0] = 1'b1; addr[0] = 32'h0000_1000; wdat[0] = 32'hDEAD_BEEF; sel[0] = 4'hF;
    we[1] = 1'b0; addr[1] = 32'h0000_2000; wdat[1] = 32'h0BAD_F00D; sel[1] = 4'h3;
    s_data = 32'h1234_5678; s_stall = 1'b0;
    cycle();
    chk("tie_grant_m0", {62'd0, grant}, 64'd1);
    chk("wr_addr", {32'd0, s_addr}, 64'h1000);
    chk("wr_data", {32'd0, s_wdat}, 64'hDEAD_BEEF);
    chk("wr_sel",  {60'd0, s_sel},  64'hF);
    chk("wr_we",   {63'd0, s_we},   64'd1);
    chk("rd_m0",   {32'd0, m0_rdat}, 64'h1234_5678);
    chk("rd_m1",   {32'd0, m1_rdat}, 64'd0);
    cycle();
    s_ack = 1'b1; cycle();
    s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0; cycle();
    chk("handover_m1", {62'd0, grant}, 64'd2);
    cycle();
    s_ack = 1'b1; cycle();
    s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; cycle(); cycle();

    // m1 locks the bus over four beats while m0 waits
    cyc[1] = 1'b1; stb[1] = 1'b1; cycle();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_ack = 1'b1; cycle();
      chk("lock_m0_stall", {63'd0, m0_stall}, 64'd1);
      s_ack = 1'b0; cycle();
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; cycle();
    chk("lock_release_m0", {62'd0, grant}, 64'd1);
    idle_inputs(); cycle(); cycle();

    // ack on the eighth strobe cycle beats the timeout
    cyc[0] = 1'b1; stb[0] = 1'b1; cycle();
    for (int i = 0; i < 7; i++) cycle();
    s_ack = 1'b1; #3;
    chk("late_ack", {63'd0, m0_ack}, 64'd1);
    chk("late_ack_no_err", {63'd0, m0_err}, 64'd0);
    cycle();
    chk("late_ack_cnt", {56'd0, abort_cnt}, 64'd0);
    idle_inputs(); cycle(); cycle();

    // slave never acks: m0 is aborted, m1 waits until m0 drops cyc
    cyc[0] = 1'b1; stb[0] = 1'b1; cycle();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    #3;
    chk("tmo_err", {63'd0, m0_err}, 64'd1);
    cycle();
    chk("tmo_s_cyc", {63'd0, s_cyc}, 64'd0);
    chk("tmo_cnt", {56'd0, abort_cnt}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("abort_no_grant", {62'd0, grant}, 64'd0);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0; cycle(); cycle();
    chk("after_abort_m1", {62'd0, grant}, 64'd2);
    idle_inputs(); cycle(); cycle();

    // drive the abort counter into saturation
    for (int n = 0; n < 258; n++) begin
      cyc[0] = 1'b1; stb[0] = 1'b1;
      for (int i = 0; i < TMO + 1; i++) cycle();
      cyc[0] = 1'b0; stb[0] = 1'b0; cycle(); cycle();
    end
    chk("abort_sat", {56'd0, abort_cnt}, 64'd255);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(7, 0) == 0) cyc[k] = ~cyc[k];
        stb[k]  = 1'($urandom_range(1, 0));
        we[k]   = 1'($urandom_range(1, 0));
        addr[k] = $urandom; wdat[k] = $urandom; sel[k] = 4'($urandom_range(15, 0));
      end
      s_ack   = ($urandom_range(5, 0) == 0);
      s_stall = 1'($urandom_range(1, 0));
      s_data  = $urandom;
      cycle();
    end

    // reset in the middle of an m1 cycle
    idle_inputs(); cycle(); cycle(); cycle();
    cyc[1] = 1'b1; stb[1] = 1'b1; cycle();
    chk("pre_reset_m1", {62'd0, grant}, 64'd2);
    s_ack = 1'b1; #2;
    rst_n = 1'b0; model_reset(); #1;
    chk("rst_s_cyc", {63'd0, s_cyc}, 64'd0);
    chk("rst_grant", {62'd0, grant}, 64'd0);
    chk("rst_cnt",   {56'd0, abort_cnt}, 64'd0);
    chk("rst_no_ack", {63'd0, m1_ack}, 64'd0);
    cycle();
    s_ack = 1'b0; cyc = 2'b11; stb = 2'b11; rst_n = 1'b1;
    cycle();
    chk("post_reset_tie_m0", {62'd0, grant}, 64'd1);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
